// File: rtl/tone_pkg.sv
// Shared constants for the organ tone path: default counter width, the note table, mixer width helper.
// Half-periods assume a 50 MHz board clock (half = clk_hz / (2 * f_note)), white keys C4..B5.
package tone_pkg;

  localparam int TONE_WIDTH   = 32;
  localparam int BOARD_CLK_HZ = 50_000_000;

  localparam logic [TONE_WIDTH-1:0] HALF_C4 = 32'd95556;
  localparam logic [TONE_WIDTH-1:0] HALF_D4 = 32'd85131;
  localparam logic [TONE_WIDTH-1:0] HALF_E4 = 32'd75843;
  localparam logic [TONE_WIDTH-1:0] HALF_F4 = 32'd71586;
  localparam logic [TONE_WIDTH-1:0] HALF_G4 = 32'd63776;
  localparam logic [TONE_WIDTH-1:0] HALF_A4 = 32'd56818;
  localparam logic [TONE_WIDTH-1:0] HALF_B4 = 32'd50619;
  localparam logic [TONE_WIDTH-1:0] HALF_C5 = 32'd47778;
  localparam logic [TONE_WIDTH-1:0] HALF_D5 = 32'd42566;
  localparam logic [TONE_WIDTH-1:0] HALF_E5 = 32'd37921;
  localparam logic [TONE_WIDTH-1:0] HALF_F5 = 32'd35793;
  localparam logic [TONE_WIDTH-1:0] HALF_G5 = 32'd31888;
  localparam logic [TONE_WIDTH-1:0] HALF_A5 = 32'd28409;
  localparam logic [TONE_WIDTH-1:0] HALF_B5 = 32'd25310;

  function automatic int mix_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tone_div_ch.sv
// One tone channel: divides clk by 2*half, toggle strobe on every edge of tone; tone changes one edge after the compare hits.
// New half-periods wait in nxt until the next toggle (no runt phase); writes are always accepted, last write wins.
module tone_div_ch
  import tone_pkg::*;
#(
  parameter int WIDTH = TONE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [WIDTH-1:0] val,
  output logic             tone,
  output logic             tick,
  output logic             pend
);

  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] nxt;
  logic             pv;
  logic             active;
  logic             wrap;

  assign active = en && (half != '0);
  assign wrap   = (cnt == half - WIDTH'(1));
  assign pend   = pv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half <= '0;
      cnt  <= '0;
      nxt  <= '0;
      pv   <= 1'b0;
      tone <= 1'b0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (!active) begin
        // Idle or disabled: park at phase 0 and take any new value straight away.
        cnt  <= '0;
        tone <= 1'b0;
        if (wr) begin
          half <= val;
          pv   <= 1'b0;
        end else if (pv) begin
          half <= nxt;
          pv   <= 1'b0;
        end
      end else begin
        if (wrap) begin
          cnt  <= '0;
          tone <= ~tone;
          tick <= 1'b1;
          if (pv) begin
            half <= nxt;
            pv   <= 1'b0;
          end
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
        // A write on the boundary edge stays pending for the following toggle.
        if (wr) begin
          nxt <= val;
          pv  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/poly_tone_div.sv
// N-channel square-wave divider with registered polyphony level (mix_level one cycle behind tone).
// Divide writes are single-cycle and always accepted; out-of-range channel indices are dropped.
module poly_tone_div
  import tone_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = TONE_WIDTH,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int MIX_W    = mix_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                div_wr,
  input  logic [CH_W-1:0]     div_ch,
  input  logic [WIDTH-1:0]    div_val,
  output logic [CHANNELS-1:0] tone,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pend,
  output logic [MIX_W-1:0]    mix_level
);

  logic [CHANNELS-1:0] wr;
  logic [MIX_W-1:0]    pop;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign wr[i] = div_wr && (div_ch == CH_W'(i));

    tone_div_ch #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en[i]),
      .wr    (wr[i]),
      .val   (div_val),
      .tone  (tone[i]),
      .tick  (tick[i]),
      .pend  (pend[i])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pop = pop + MIX_W'(tone[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mix_level <= '0;
    end else begin
      mix_level <= pop;
    end
  end

endmodule

// File: tb/tb_poly_tone_div.sv
// Directed bench: expected toggle events are queued by the stimulus and retired by a tick monitor.
module tb_poly_tone_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  en;
  logic        div_wr;
  logic [1:0]  div_ch;
  logic [31:0] div_val;
  logic [3:0]  tone;
  logic [3:0]  tick;
  logic [3:0]  pend;
  logic [2:0]  mix_level;

  poly_tone_div #(.CHANNELS(4), .WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .div_wr    (div_wr),
    .div_ch    (div_ch),
    .div_val   (div_val),
    .tone      (tone),
    .tick      (tick),
    .pend      (pend),
    .mix_level (mix_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ch;
    int cyc;
    bit tone;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push(input int ch, input int c, input bit t);
    exp_t e;
    e.ch = ch; e.cyc = c; e.tone = t;
    sb.push_back(e);
  endtask

  task automatic push_run(input int ch, input int base, input int h, input int kmax);
    for (int k = 1; k <= kmax; k++) push(ch, base + h * k, bit'(k % 2));
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int val, output int n);
    div_wr  = 1'b1;
    div_ch  = 2'(ch);
    div_val = val;
    n = cyc;
    @(negedge clk);
    div_wr  = 1'b0;
  endtask

  function automatic bit exp_tone(input int t, input int b, input int h);
    if (t < b + h) return 1'b0;
    return ((t - b) / h) % 2 == 1;
  endfunction

  // Monitor: every tick must match the oldest queued event for that channel.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (tick[c]) begin
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (idx < 0 && sb[i].ch == c) idx = i;
        end
        tests++;
        if (idx < 0) begin
          fails++;
          $display("FAIL tick_unexpected ch%0d: tick at cycle %0d, none expected", c, cyc);
        end else begin
          if (sb[idx].cyc != cyc || sb[idx].tone != tone[c]) begin
            fails++;
            $display("FAIL tick ch%0d: got cycle %0d tone %0d, expected cycle %0d tone %0d",
                     c, cyc, tone[c], sb[idx].cyc, sb[idx].tone);
          end
          sb.delete(idx);
        end
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL tick_missing ch%0d: no tick by cycle %0d, expected at %0d", sb[i].ch, cyc, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n, l, b, p;
    int pc;
    rst_n   = 1'b0;
    en      = 4'b0000;
    div_wr  = 1'b0;
    div_ch  = 2'd0;
    div_val = 32'd0;

    repeat (3) @(negedge clk);
    chk("rst_tone", int'(tone), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_pend", int'(pend), 0);
    chk("rst_mix", int'(mix_level), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ch0: half=3 from idle
    en = 4'b0001;
    wr(0, 3, n);
    l = n + 1;
    push_run(0, l, 3, 4);
    wait_cyc(l + 1); chk("ch0_low_phase", int'(tone[0]), 0);
    wait_cyc(l + 2); chk("ch0_still_low", int'(tone[0]), 0);
    wait_cyc(l + 3); chk("ch0_first_rise", int'(tone[0]), 1);
    wait_cyc(l + 4); chk("ch0_pend", int'(pend[0]), 0);
    wait_cyc(l + 12);
    en = 4'b0000;

    // ch1: half=4, rewritten to 2 mid high phase
    en = 4'b0010;
    wr(1, 4, n);
    l = n + 1;
    push(1, l + 4, 1); push(1, l + 8, 0); push(1, l + 10, 1);
    push(1, l + 12, 0); push(1, l + 14, 1);
    wait_cyc(l + 5);
    wr(1, 2, n);
    chk("ch1_pend_set", int'(pend[1]), 1);
    wait_cyc(l + 7); chk("ch1_pend_hold", int'(pend[1]), 1);
    chk("ch1_high_phase", int'(tone[1]), 1);
    wait_cyc(l + 8); chk("ch1_pend_clr", int'(pend[1]), 0);
    wait_cyc(l + 14);
    en = 4'b0000;

    // ch2: two writes before boundary, then a write on a toggle edge
    en = 4'b0100;
    wr(2, 6, n);
    l = n + 1;
    push(2, l + 6, 1); push(2, l + 13, 0); push(2, l + 20, 1);
    push(2, l + 27, 0); push(2, l + 30, 1); push(2, l + 33, 0);
    wait_cyc(l + 2);
    wr(2, 5, n);
    wr(2, 7, n);
    wait_cyc(l + 5); chk("ch2_pend_multi", int'(pend[2]), 1);
    wait_cyc(l + 19);
    wr(2, 3, n);
    chk("ch2_pend_coincident", int'(pend[2]), 1);
    chk("ch2_tone_coincident", int'(tone[2]), 1);
    wait_cyc(l + 27); chk("ch2_pend_applied", int'(pend[2]), 0);
    wait_cyc(l + 33);
    en = 4'b0000;

    // ch3: drop enable with a pending value, then re-enable
    en = 4'b1000;
    wr(3, 5, n);
    l = n + 1;
    push(3, l + 5, 1); push(3, l + 10, 0); push(3, l + 15, 1);
    push(3, l + 22, 1); push(3, l + 24, 0); push(3, l + 26, 1);
    wait_cyc(l + 16);
    wr(3, 2, n);
    chk("ch3_pend_set", int'(pend[3]), 1);
    chk("ch3_high_before_drop", int'(tone[3]), 1);
    en = 4'b0000;
    wait_cyc(l + 18);
    chk("ch3_drop_tone", int'(tone[3]), 0);
    chk("ch3_drop_pend", int'(pend[3]), 0);
    wait_cyc(l + 20);
    en = 4'b1000;
    wait_cyc(l + 21); chk("ch3_reen_low", int'(tone[3]), 0);
    wait_cyc(l + 22); chk("ch3_reen_rise", int'(tone[3]), 1);
    wait_cyc(l + 26);
    en = 4'b0000;

    // all channels at half 1..4 started together, mixer check, then silence ch3
    wr(0, 1, n); wr(1, 2, n); wr(2, 3, n); wr(3, 4, n);
    en = 4'b1111;
    b = cyc;
    push_run(0, b, 1, 24);
    push_run(1, b, 2, 12);
    push_run(2, b, 3, 8);
    push_run(3, b, 4, 5);
    for (int t = b + 1; t <= b + 20; t++) begin
      wait_cyc(t);
      if (t == b + 17) begin
        div_wr = 1'b1; div_ch = 2'd3; div_val = 32'd0;
      end else begin
        div_wr = 1'b0;
      end
      pc = 0;
      for (int c = 0; c < 4; c++) pc += int'(exp_tone(t - 1, b, c + 1));
      chk("mix_level", int'(mix_level), pc);
      chk("tone_vec", int'(tone), {28'd0, exp_tone(t, b, 4), exp_tone(t, b, 3),
                                   exp_tone(t, b, 2), exp_tone(t, b, 1)});
      if (t == b + 16) chk("mix_full", int'(mix_level), 4);
      if (t == b + 18) chk("ch3_zero_pend", int'(pend[3]), 1);
      if (t == b + 20) chk("ch3_zero_applied", int'(pend[3]), 0);
    end
    div_wr = 1'b0;
    wait_cyc(b + 21); chk("ch3_silenced", int'(tone[3]), 0);
    wait_cyc(b + 24);
    en = 4'b0000;
    wait_cyc(b + 28); chk("ch3_stays_silent", int'(tone[3]), 0);

    // reset mid-tone with a pending write
    wr(0, 10, n); wr(1, 10, n);
    en = 4'b0011;
    p = cyc;
    push(0, p + 10, 1); push(1, p + 10, 1);
    wait_cyc(p + 11);
    wr(0, 3, n);
    chk("pre_rst_pend", int'(pend[0]), 1);
    chk("pre_rst_mix", int'(mix_level), 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tone", int'(tone), 0);
    chk("mid_rst_pend", int'(pend), 0);
    chk("mid_rst_mix", int'(mix_level), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p = cyc;
    wait_cyc(p + 30);
    chk("post_rst_tone", int'(tone), 0);
    chk("post_rst_pend", int'(pend), 0);
    chk("post_rst_mix", int'(mix_level), 0);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
